// File: rtl/proc_pkg.sv
// Shared types and default timing constants for the Start/CountEn program launcher.
package proc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOLD_ST,
        RUN,
        RECORD,
        FINISH
    } launch_state_t;

    localparam int          DEF_HOLD    = 2;
    localparam int          DEF_CYC_W   = 16;
    localparam int unsigned DEF_TIMEOUT = 32'h0000_FFFF;

endpackage

// File: rtl/prog_launcher.sv
// Drives the processor Start line through a batch of back-to-back program runs,
// timing each run and flagging runs that hit the cycle limit.
module prog_launcher
    import proc_pkg::*;
#(
    parameter int          PROG_W  = 2,
    parameter int          CYC_W   = DEF_CYC_W,
    parameter int          HOLD    = DEF_HOLD,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Go,
    input  logic [PROG_W:0]   NumProgs,
    input  logic              Done,
    output logic              Start,
    output logic [PROG_W-1:0] ProgIdx,
    output logic [CYC_W-1:0]  LastCycles,
    output logic              CycValid,
    output logic              Busy,
    output logic              BatchDone,
    output logic              TimedOut
);

    localparam logic [CYC_W-1:0] HOLD_LAST = CYC_W'(HOLD - 1);
    localparam logic [CYC_W-1:0] RUN_LAST  = CYC_W'(TIMEOUT - 1);
    localparam logic [CYC_W-1:0] CNT_ONE   = CYC_W'(1);
    localparam logic [PROG_W:0]  MAX_PROGS = (PROG_W + 1)'(2 ** PROG_W);
    localparam logic [PROG_W:0]  NP_ONE    = (PROG_W + 1)'(1);

    launch_state_t     state;
    logic [CYC_W-1:0]  cnt;       // hold counter in HOLD_ST, run-cycle counter in RUN
    logic [PROG_W-1:0] last_idx;

    // A count of 0 runs one program; counts beyond the index range are clamped so
    // the batch always terminates.
    function automatic logic [PROG_W-1:0] last_index(input logic [PROG_W:0] n);
        logic [PROG_W:0] c;
        if (n == '0)
            c = NP_ONE;
        else if (n > MAX_PROGS)
            c = MAX_PROGS;
        else
            c = n;
        return PROG_W'(c - NP_ONE);
    endfunction

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            cnt        <= '0;
            last_idx   <= '0;
            Start      <= 1'b1;
            ProgIdx    <= '0;
            LastCycles <= '0;
            CycValid   <= 1'b0;
            Busy       <= 1'b0;
            BatchDone  <= 1'b0;
            TimedOut   <= 1'b0;
        end else begin
            CycValid  <= 1'b0;
            BatchDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (Go) begin
                        last_idx <= last_index(NumProgs);
                        TimedOut <= 1'b0;
                        ProgIdx  <= '0;
                        cnt      <= '0;
                        Busy     <= 1'b1;
                        state    <= HOLD_ST;
                    end
                end
                HOLD_ST: begin
                    if (cnt == HOLD_LAST) begin
                        cnt   <= '0;
                        Start <= 1'b0;
                        state <= RUN;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                RUN: begin
                    // Done wins over a coincident timeout; cnt+1 counts this final cycle.
                    if (Done || (cnt == RUN_LAST)) begin
                        if (!Done)
                            TimedOut <= 1'b1;
                        LastCycles <= cnt + CNT_ONE;
                        CycValid   <= 1'b1;
                        Start      <= 1'b1;
                        state      <= RECORD;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                RECORD: begin
                    if (ProgIdx == last_idx) begin
                        BatchDone <= 1'b1;
                        state     <= FINISH;
                    end else begin
                        ProgIdx <= ProgIdx + PROG_W'(1);
                        cnt     <= '0;
                        state   <= HOLD_ST;
                    end
                end
                FINISH: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_launcher.sv
// Directed batch vectors plus hand-written reset/hold corner sequences for prog_launcher.
module tb_prog_launcher;

    localparam int PROG_W  = 2;
    localparam int CYC_W   = 16;
    localparam int HOLD    = 2;
    localparam int TIMEOUT = 10;
    localparam int BOUND   = 50;

    logic              Clk;
    logic              Reset;
    logic              Go;
    logic [PROG_W:0]   NumProgs;
    logic              Done;
    logic              Start;
    logic [PROG_W-1:0] ProgIdx;
    logic [CYC_W-1:0]  LastCycles;
    logic              CycValid;
    logic              Busy;
    logic              BatchDone;
    logic              TimedOut;

    prog_launcher #(
        .PROG_W (PROG_W),
        .CYC_W  (CYC_W),
        .HOLD   (HOLD),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Go        (Go),
        .NumProgs  (NumProgs),
        .Done      (Done),
        .Start     (Start),
        .ProgIdx   (ProgIdx),
        .LastCycles(LastCycles),
        .CycValid  (CycValid),
        .Busy      (Busy),
        .BatchDone (BatchDone),
        .TimedOut  (TimedOut)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [2:0]      np_in;
        logic [7:0]      exp_np;
        logic [3:0][7:0] lens;     // 0 = Done never asserted
        logic [3:0][7:0] exp_cyc;
        logic            exp_to;
        logic            go_noise; // pulse Go during every RUN cycle
    } vec_t;

    int n_vec;
    int n_bad;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic count_start(input logic lvl, output int n);
        n = 0;
        while (Start == lvl && n < BOUND) begin
            n++;
            @(negedge Clk);
        end
    endtask

    function automatic vec_t mk(input int np, input int enp, input int l0, input int l1,
                                input int l2, input int l3, input int c0, input int c1,
                                input int c2, input int c3, input bit to, input bit gn);
        vec_t v;
        v.np_in      = 3'(np);
        v.exp_np     = 8'(enp);
        v.lens[0]    = 8'(l0);
        v.lens[1]    = 8'(l1);
        v.lens[2]    = 8'(l2);
        v.lens[3]    = 8'(l3);
        v.exp_cyc[0] = 8'(c0);
        v.exp_cyc[1] = 8'(c1);
        v.exp_cyc[2] = 8'(c2);
        v.exp_cyc[3] = 8'(c3);
        v.exp_to     = to;
        v.go_noise   = gn;
        return v;
    endfunction

    // Called on a negedge while idle; returns on the negedge after Busy drops.
    task automatic do_batch(input vec_t v, input int id);
        int hi;
        int lo;
        Go       = 1'b1;
        NumProgs = v.np_in;
        @(negedge Clk);
        Go       = 1'b0;
        NumProgs = '0;
        chk($sformatf("v%0d busy_after_go", id), int'(Busy), 1);
        chk($sformatf("v%0d timedout_cleared", id), int'(TimedOut), 0);
        for (int p = 0; p < int'(v.exp_np); p++) begin
            count_start(1'b1, hi);
            chk($sformatf("v%0d p%0d start_high_cycles", id, p), hi, (p == 0) ? HOLD : HOLD + 1);
            chk($sformatf("v%0d p%0d prog_idx", id, p), int'(ProgIdx), p);
            lo = 0;
            while (!Start && lo < BOUND) begin
                lo++;
                Done = (lo == int'(v.lens[p]));
                if (v.go_noise) begin
                    Go       = 1'b1;
                    NumProgs = 3'd1;
                end
                @(negedge Clk);
            end
            Done     = 1'b0;
            Go       = 1'b0;
            NumProgs = '0;
            chk($sformatf("v%0d p%0d start_low_cycles", id, p), lo, int'(v.exp_cyc[p]));
            chk($sformatf("v%0d p%0d last_cycles", id, p), int'(LastCycles), int'(v.exp_cyc[p]));
            chk($sformatf("v%0d p%0d cyc_valid", id, p), int'(CycValid), 1);
        end
        @(negedge Clk);
        chk($sformatf("v%0d batch_done", id), int'(BatchDone), 1);
        chk($sformatf("v%0d cyc_valid_drop", id), int'(CycValid), 0);
        chk($sformatf("v%0d busy_in_finish", id), int'(Busy), 1);
        chk($sformatf("v%0d timedout_at_done", id), int'(TimedOut), int'(v.exp_to));
        @(negedge Clk);
        chk($sformatf("v%0d busy_dropped", id), int'(Busy), 0);
        chk($sformatf("v%0d batch_done_pulse", id), int'(BatchDone), 0);
        chk($sformatf("v%0d start_idle", id), int'(Start), 1);
        chk($sformatf("v%0d timedout_held", id), int'(TimedOut), int'(v.exp_to));
    endtask

    vec_t vecs[7];

    initial begin
        int hi;
        int lo;
        n_vec    = 0;
        n_bad    = 0;
        Reset    = 1'b1;
        Go       = 1'b0;
        Done     = 1'b0;
        NumProgs = '0;

        vecs[0] = mk(1, 1, 5, 0, 0, 0, 5, 0, 0, 0, 1'b0, 1'b0);
        vecs[1] = mk(3, 3, 3, 7, 1, 0, 3, 7, 1, 0, 1'b0, 1'b0);
        vecs[2] = mk(2, 2, 0, 4, 0, 0, 10, 4, 0, 0, 1'b1, 1'b0);
        vecs[3] = mk(1, 1, 10, 0, 0, 0, 10, 0, 0, 0, 1'b0, 1'b0);
        vecs[4] = mk(0, 1, 2, 0, 0, 0, 2, 0, 0, 0, 1'b0, 1'b0);
        vecs[5] = mk(2, 2, 2, 3, 0, 0, 2, 3, 0, 0, 1'b0, 1'b1);
        vecs[6] = mk(4, 4, 1, 2, 0, 3, 1, 2, 10, 3, 1'b1, 1'b0);

        #1;
        chk("rst start", int'(Start), 1);
        chk("rst prog_idx", int'(ProgIdx), 0);
        chk("rst last_cycles", int'(LastCycles), 0);
        chk("rst cyc_valid", int'(CycValid), 0);
        chk("rst busy", int'(Busy), 0);
        chk("rst batch_done", int'(BatchDone), 0);
        chk("rst timed_out", int'(TimedOut), 0);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk("idle start", int'(Start), 1);

        for (int i = 0; i < 7; i++)
            do_batch(vecs[i], i);

        // Done held high through HOLD_ST is ignored; the run still lasts one cycle.
        Done     = 1'b1;
        Go       = 1'b1;
        NumProgs = 3'd1;
        @(negedge Clk);
        Go = 1'b0;
        count_start(1'b1, hi);
        chk("done_in_hold start_high", hi, HOLD);
        count_start(1'b0, lo);
        Done = 1'b0;
        chk("done_in_hold run_len", lo, 1);
        chk("done_in_hold last_cycles", int'(LastCycles), 1);
        chk("done_in_hold cyc_valid", int'(CycValid), 1);
        @(negedge Clk);
        @(negedge Clk);
        chk("done_in_hold idle", int'(Busy), 0);

        // Asynchronous reset in the middle of program 1's run.
        Go       = 1'b1;
        NumProgs = 3'd3;
        @(negedge Clk);
        Go = 1'b0;
        count_start(1'b1, hi);
        Done = 1'b1;
        @(negedge Clk);
        Done = 1'b0;
        count_start(1'b1, hi);
        chk("midrun prog_idx_before", int'(ProgIdx), 1);
        chk("midrun start_low_before", int'(Start), 0);
        @(negedge Clk);
        #1 Reset = 1'b1;
        #1;
        chk("midrun rst start", int'(Start), 1);
        chk("midrun rst busy", int'(Busy), 0);
        chk("midrun rst prog_idx", int'(ProgIdx), 0);
        chk("midrun rst last_cycles", int'(LastCycles), 0);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk("midrun stays idle", int'(Busy), 0);
        do_batch(vecs[1], 7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/prog_launcher.md
# prog_launcher

Initiator side of the Start/CountEn program-run handshake. Given a Go request, it drives the processor's Start line to run a batch of programs back to back. For each program it holds Start high long enough for the program-counter enable to arm, releases Start so the processor runs, and waits for the processor's Done flag. It reports the cycle count of each run and a batch-complete flag, replacing hand-written testbench Start sequencing at the top of the 3BC processor harness.

## Interface
- PROG_W, 2: width of program index; batch holds up to 2**PROG_W programs
- CYC_W, 16: width of per-program cycle counter
- HOLD, 2: cycles Start stays high before each release (≥1)
- TIMEOUT, 16'hFFFF: run-cycle limit per program; reaching it aborts that program
- Clk  in  1  clock; all state on posedge
- Reset  in  1  asynchronous, active-high reset
- Go  in  1  one-cycle request to start a batch; ignored unless idle
- NumProgs  in  PROG_W+1  programs in batch, sampled with Go; 0 treated as 1
- Done  in  1  processor halt flag; only meaningful while Start is low
- Start  out  1  to processor; high = hold/load, falling edge = begin counting
- ProgIdx  out  PROG_W  index of program currently launched/running
- LastCycles  out  CYC_W  run cycles of most recently finished program
- CycValid  out  1  one-cycle pulse when LastCycles updates
- Busy  out  1  batch in progress
- BatchDone  out  1  one-cycle pulse after last program finishes
- TimedOut  out  1  sticky per batch; set if any program hit TIMEOUT

## Operation
- States: IDLE, HOLD_ST, RUN, RECORD, FINISH.
- IDLE: Start=1, Busy=0. Go=1 latches NumProgs (0→1), clears TimedOut, ProgIdx=0, goes to HOLD_ST.
- HOLD_ST: Start=1, Busy=1. Hold counter runs HOLD cycles, then goes to RUN; the cycle counter clears on entry to RUN.
- RUN: Start=0. The cycle counter increments every RUN cycle.
  - Done=1 → RECORD.
  - Counter == TIMEOUT-1 with no Done → set TimedOut, then RECORD.
  - Done and timeout in the same cycle → treated as Done; TimedOut stays unchanged.
- RECORD (one cycle): Start=1. LastCycles ← counter value including the final RUN cycle. CycValid=1.
  - If ProgIdx == latched count-1 → FINISH.
  - Otherwise ProgIdx+1 → HOLD_ST.
- FINISH (one cycle): Start=1, BatchDone=1, Busy=0 next cycle → IDLE.
- Go outside IDLE is ignored. Done outside RUN is ignored.
- Counter arithmetic is unsigned CYC_W and never wraps: timeout fires before overflow. Require TIMEOUT ≤ 2**CYC_W-1.

## Timing
- Reset values: Start=1, ProgIdx=0, LastCycles=0, CycValid=0, Busy=0, BatchDone=0, TimedOut=0, state IDLE. All apply immediately (async).
- Start is registered, so there are no glitches; Start only changes on posedge Clk.
- Go at edge k → Busy=1 after k. Start falls after edge k+HOLD. The first RUN cycle is the cycle following that edge.
- Done sampled high at the edge ending run cycle n → LastCycles=n and CycValid in the next cycle. Start rises at that same edge.
- Per-program overhead: RECORD 1 cycle + HOLD cycles with Start high before the next release.
- Reset mid-batch: immediate return to IDLE with Start=1, so the processor stops counting. The batch is not resumed.

## Structure
- Shared package proc_pkg holds the state enum (launch_state_t) and default constants for HOLD, TIMEOUT and CYC_W.
- A single module; there are no sub-modules. The hold counter and the cycle counter share one CYC_W register, since they are never active together.

## Test plan
- Reset while idle → Start=1, all other outputs 0. Go with NumProgs=1, HOLD=2, Done after 5 RUN cycles → Start low for exactly 5 cycles, LastCycles=5, CycValid one pulse, BatchDone one pulse, Busy drops.
- NumProgs=3, Done after 3, 7, 1 cycles → ProgIdx steps 0,1,2. LastCycles sequence is 3, 7, 1. Start high for HOLD+1 cycles between runs.
- TIMEOUT=10, Done never asserted → LastCycles=10, TimedOut=1, batch continues to the next program and TimedOut stays set through BatchDone. The next Go clears TimedOut.
- Done and timeout in the same cycle → TimedOut stays 0, LastCycles=TIMEOUT. Done held high during HOLD_ST → ignored, RUN still lasts ≥1 cycle.
- Go pulsed while Busy → no effect on ProgIdx or count. NumProgs=0 → runs exactly one program.
- Reset asserted mid-RUN → Start=1 asynchronously, Busy=0, ProgIdx=0. A subsequent Go restarts cleanly from program 0.
